// File: rtl/bsg_nasti_pkg.sv
// bsg_nasti_pkg: shared NASTI packet types, widths and helpers
package bsg_nasti_pkg;
  localparam int bsg_nasti_id_width_gp = 6;
  typedef struct packed {
    logic [bsg_nasti_id_width_gp-1:0] id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } bsg_nasti_a_pkt;
  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  strb;
    logic        last;
  } bsg_nasti_w_pkt;
  typedef struct packed {
    logic [bsg_nasti_id_width_gp-1:0] id;
    logic [1:0] resp;
  } bsg_nasti_b_pkt;
  typedef struct packed {
    logic [bsg_nasti_id_width_gp-1:0] id;
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
  } bsg_nasti_r_pkt;
  typedef enum logic {W_IDLE, W_BURST} w_state_e;
  function automatic int safe_clog2(input int n);
    return n < 2 ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/bsg_nasti_rr_lock_arb.sv
// bsg_nasti_rr_lock_arb: round-robin arbiter that holds its grant until the handshake
module bsg_nasti_rr_lock_arb
  import bsg_nasti_pkg::*;
#(
  parameter int num_p = 2,
  parameter int lg_p  = safe_clog2(num_p)
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic [num_p-1:0] v_i,
  input  logic             ready_i,
  input  logic             en_i,
  output logic [num_p-1:0] grant_o,
  output logic [lg_p-1:0]  grant_idx_o,
  output logic             valid_o
);
  logic [lg_p-1:0] ptr_r, grant_r, scan_idx, j;
  logic lock_r, scan_v;
  always_comb begin
    scan_v = 1'b0;
    scan_idx = '0;
    j = '0;
    for (int k = num_p - 1; k >= 0; k--) begin
      j = lg_p'((int'(ptr_r) + k) % num_p);
      scan_v = v_i[j] ? 1'b1 : scan_v;
      scan_idx = v_i[j] ? j : scan_idx;
    end
  end
  assign grant_idx_o = lock_r ? grant_r : scan_idx;
  assign valid_o = reset_n_i & en_i & (lock_r ? v_i[grant_r] : scan_v);
  assign grant_o = valid_o ? num_p'(1) << grant_idx_o : '0;
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      ptr_r <= '0;
      lock_r <= 1'b0;
      grant_r <= '0;
    end else if (valid_o && ready_i) begin
      ptr_r <= (grant_idx_o == lg_p'(num_p - 1)) ? '0 : grant_idx_o + 1'b1;
      lock_r <= 1'b0;
    end else if (valid_o) begin
      lock_r <= 1'b1;
      grant_r <= grant_idx_o;
    end
  end
endmodule

// File: rtl/bsg_nasti_arbiter.sv
// bsg_nasti_arbiter: shares one NASTI master port between several clients via id tagging
module bsg_nasti_arbiter
  import bsg_nasti_pkg::*;
#(
  parameter  int num_clients_p = 2,
  localparam int lg_clients_lp = safe_clog2(num_clients_p)
) (
  input  logic                                 clk_i,
  input  logic                                 reset_n_i,
  input  logic           [num_clients_p-1:0]   client_ar_valid_i,
  input  bsg_nasti_a_pkt [num_clients_p-1:0]   client_ar_data_i,
  output logic           [num_clients_p-1:0]   client_ar_ready_o,
  input  logic           [num_clients_p-1:0]   client_aw_valid_i,
  input  bsg_nasti_a_pkt [num_clients_p-1:0]   client_aw_data_i,
  output logic           [num_clients_p-1:0]   client_aw_ready_o,
  input  logic           [num_clients_p-1:0]   client_w_valid_i,
  input  bsg_nasti_w_pkt [num_clients_p-1:0]   client_w_data_i,
  output logic           [num_clients_p-1:0]   client_w_ready_o,
  output logic           [num_clients_p-1:0]   client_b_valid_o,
  output bsg_nasti_b_pkt                       client_b_data_o,
  input  logic           [num_clients_p-1:0]   client_b_ready_i,
  output logic           [num_clients_p-1:0]   client_r_valid_o,
  output bsg_nasti_r_pkt                       client_r_data_o,
  input  logic           [num_clients_p-1:0]   client_r_ready_i,
  output logic                                 master_ar_valid_o,
  output bsg_nasti_a_pkt                       master_ar_data_o,
  input  logic                                 master_ar_ready_i,
  output logic                                 master_aw_valid_o,
  output bsg_nasti_a_pkt                       master_aw_data_o,
  input  logic                                 master_aw_ready_i,
  output logic                                 master_w_valid_o,
  output bsg_nasti_w_pkt                       master_w_data_o,
  input  logic                                 master_w_ready_i,
  input  logic                                 master_b_valid_i,
  input  bsg_nasti_b_pkt                       master_b_data_i,
  output logic                                 master_b_ready_o,
  input  logic                                 master_r_valid_i,
  input  bsg_nasti_r_pkt                       master_r_data_i,
  output logic                                 master_r_ready_o
);
  localparam int id_hi_lp = bsg_nasti_id_width_gp - 1;
  logic [num_clients_p-1:0] ar_grant, aw_grant;
  logic [lg_clients_lp-1:0] ar_idx, aw_idx, w_owner_r, b_dest, r_dest;
  logic aw_hs, w_active;
  w_state_e w_state_r, w_state_n;
  bsg_nasti_rr_lock_arb #(.num_p(num_clients_p), .lg_p(lg_clients_lp)) ar_arb (
    .clk_i, .reset_n_i, .v_i(client_ar_valid_i), .ready_i(master_ar_ready_i), .en_i(1'b1),
    .grant_o(ar_grant), .grant_idx_o(ar_idx), .valid_o(master_ar_valid_o)
  );
  bsg_nasti_rr_lock_arb #(.num_p(num_clients_p), .lg_p(lg_clients_lp)) aw_arb (
    .clk_i, .reset_n_i, .v_i(client_aw_valid_i), .ready_i(master_aw_ready_i),
    .en_i(w_state_r == W_IDLE), .grant_o(aw_grant), .grant_idx_o(aw_idx), .valid_o(master_aw_valid_o)
  );
  assign client_ar_ready_o = ar_grant & {num_clients_p{master_ar_ready_i}};
  assign client_aw_ready_o = aw_grant & {num_clients_p{master_aw_ready_i}};
  assign aw_hs = master_aw_valid_o & master_aw_ready_i;
  assign w_active = reset_n_i & (w_state_r == W_BURST);
  assign master_w_valid_o = w_active & client_w_valid_i[w_owner_r];
  assign master_w_data_o = client_w_data_i[w_owner_r];
  assign client_w_ready_o = w_active ? (num_clients_p'(1) << w_owner_r) & {num_clients_p{master_w_ready_i}} : '0;
  assign b_dest = master_b_data_i.id[id_hi_lp -: lg_clients_lp];
  assign r_dest = master_r_data_i.id[id_hi_lp -: lg_clients_lp];
  assign client_b_valid_o = (reset_n_i & master_b_valid_i) ? num_clients_p'(1) << b_dest : '0;
  assign client_r_valid_o = (reset_n_i & master_r_valid_i) ? num_clients_p'(1) << r_dest : '0;
  assign master_b_ready_o = reset_n_i & client_b_ready_i[b_dest];
  assign master_r_ready_o = reset_n_i & client_r_ready_i[r_dest];
  always_comb begin
    master_ar_data_o = client_ar_data_i[ar_idx];
    master_ar_data_o.id[id_hi_lp -: lg_clients_lp] = ar_idx;
    master_aw_data_o = client_aw_data_i[aw_idx];
    master_aw_data_o.id[id_hi_lp -: lg_clients_lp] = aw_idx;
    client_b_data_o = master_b_data_i;
    client_b_data_o.id[id_hi_lp -: lg_clients_lp] = '0;
    client_r_data_o = master_r_data_i;
    client_r_data_o.id[id_hi_lp -: lg_clients_lp] = '0;
  end
  always_comb begin
    w_state_n = w_state_r;
    w_state_n = (w_state_r == W_IDLE && aw_hs) ? W_BURST
              : (master_w_valid_o && master_w_ready_i && master_w_data_o.last) ? W_IDLE : w_state_n;
  end
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) w_state_r <= W_IDLE;
    else w_state_r <= w_state_n;
    if (reset_n_i && aw_hs) w_owner_r <= aw_idx;
  end
  for (genvar i = 0; i < num_clients_p; i++) begin : g_tag_chk
    assert property (@(posedge clk_i) disable iff (!reset_n_i)
      client_ar_valid_i[i] |-> client_ar_data_i[i].id[id_hi_lp -: lg_clients_lp] == '0);
    assert property (@(posedge clk_i) disable iff (!reset_n_i)
      client_aw_valid_i[i] |-> client_aw_data_i[i].id[id_hi_lp -: lg_clients_lp] == '0);
  end
  assert property (@(posedge clk_i) disable iff (!reset_n_i)
    master_b_valid_i |-> int'(b_dest) < num_clients_p) else $fatal(1, "b dest out of range");
  assert property (@(posedge clk_i) disable iff (!reset_n_i)
    master_r_valid_i |-> int'(r_dest) < num_clients_p) else $fatal(1, "r dest out of range");
endmodule

// File: tb/tb_bsg_nasti_arbiter.sv
// tb_bsg_nasti_arbiter: scoreboard bench for the two-client NASTI arbiter
module tb_bsg_nasti_arbiter;
  import bsg_nasti_pkg::*;
  logic clk_i = 1'b0, reset_n_i;
  logic [1:0] client_ar_valid_i, client_ar_ready_o, client_aw_valid_i, client_aw_ready_o;
  logic [1:0] client_w_valid_i, client_w_ready_o, client_b_valid_o, client_b_ready_i;
  logic [1:0] client_r_valid_o, client_r_ready_i;
  bsg_nasti_a_pkt [1:0] client_ar_data_i, client_aw_data_i;
  bsg_nasti_w_pkt [1:0] client_w_data_i;
  bsg_nasti_b_pkt client_b_data_o, master_b_data_i;
  bsg_nasti_r_pkt client_r_data_o, master_r_data_i;
  bsg_nasti_a_pkt master_ar_data_o, master_aw_data_o;
  bsg_nasti_w_pkt master_w_data_o;
  logic master_ar_valid_o, master_ar_ready_i, master_aw_valid_o, master_aw_ready_i;
  logic master_w_valid_o, master_w_ready_i, master_b_valid_i, master_b_ready_o;
  logic master_r_valid_i, master_r_ready_o;
  logic [14:0] hs_outs;
  logic [127:0] ar_q[$], aw_q[$], w_q[$], b_q[$], r_q[$];
  int vectors = 0, miscompares = 0;
  bsg_nasti_arbiter #(.num_clients_p(2)) dut (
    .clk_i, .reset_n_i,
    .client_ar_valid_i, .client_ar_data_i, .client_ar_ready_o,
    .client_aw_valid_i, .client_aw_data_i, .client_aw_ready_o,
    .client_w_valid_i, .client_w_data_i, .client_w_ready_o,
    .client_b_valid_o, .client_b_data_o, .client_b_ready_i,
    .client_r_valid_o, .client_r_data_o, .client_r_ready_i,
    .master_ar_valid_o, .master_ar_data_o, .master_ar_ready_i,
    .master_aw_valid_o, .master_aw_data_o, .master_aw_ready_i,
    .master_w_valid_o, .master_w_data_o, .master_w_ready_i,
    .master_b_valid_i, .master_b_data_i, .master_b_ready_o,
    .master_r_valid_i, .master_r_data_i, .master_r_ready_o
  );
  always #5 clk_i = ~clk_i;
  assign hs_outs = {client_ar_ready_o, client_aw_ready_o, client_w_ready_o, client_b_valid_o,
                    client_r_valid_o, master_ar_valid_o, master_aw_valid_o, master_w_valid_o,
                    master_b_ready_o, master_r_ready_o};
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask
  function automatic bsg_nasti_a_pkt mk_a(input logic [5:0] id, input logic [31:0] addr, input logic [7:0] len);
    return '{id: id, addr: addr, len: len, size: 3'd3, burst: 2'd1};
  endfunction
  function automatic bsg_nasti_w_pkt mk_w(input logic [63:0] d, input logic last);
    return '{data: d, strb: 8'hff, last: last};
  endfunction
  function automatic bsg_nasti_r_pkt mk_r(input logic [5:0] id, input logic [63:0] d);
    return '{id: id, data: d, resp: 2'd0, last: 1'b1};
  endfunction
  function automatic logic [127:0] tagged_a(input bsg_nasti_a_pkt p, input int c);
    p.id[5] = 1'(c);
    return 128'(p);
  endfunction
  always @(negedge clk_i) begin
    if (reset_n_i && master_ar_valid_o && master_ar_ready_i)
      chk("ar_pkt", 128'(master_ar_data_o), ar_q.size() != 0 ? ar_q.pop_front() : {128{1'b1}});
    if (reset_n_i && master_aw_valid_o && master_aw_ready_i)
      chk("aw_pkt", 128'(master_aw_data_o), aw_q.size() != 0 ? aw_q.pop_front() : {128{1'b1}});
    if (reset_n_i && master_w_valid_o && master_w_ready_i)
      chk("w_beat", 128'(master_w_data_o), w_q.size() != 0 ? w_q.pop_front() : {128{1'b1}});
    for (int i = 0; i < 2; i++) begin
      if (client_b_valid_o[i] && client_b_ready_i[i])
        chk("b_pkt", {8'(i), client_b_data_o}, b_q.size() != 0 ? b_q.pop_front() : {128{1'b1}});
      if (client_r_valid_o[i] && client_r_ready_i[i])
        chk("r_pkt", {8'(i), client_r_data_o}, r_q.size() != 0 ? r_q.pop_front() : {128{1'b1}});
    end
  end
  initial begin
    reset_n_i = 1'b0;
    {client_ar_valid_i, client_aw_valid_i, client_w_valid_i, client_b_ready_i, client_r_ready_i} = '0;
    {client_ar_data_i, client_aw_data_i, client_w_data_i, master_b_data_i, master_r_data_i} = '0;
    {master_ar_ready_i, master_aw_ready_i, master_w_ready_i, master_b_valid_i, master_r_valid_i} = '0;
    step();
    @(negedge clk_i) chk("rst_outs", 128'(hs_outs), 0);
    step();
    reset_n_i = 1'b1;
    client_ar_data_i[0] = mk_a(6'd1, 32'h100, 8'd0);
    client_ar_data_i[1] = mk_a(6'd2, 32'h200, 8'd0);
    client_ar_valid_i = 2'b11;
    master_ar_ready_i = 1'b1;
    ar_q.push_back(tagged_a(client_ar_data_i[0], 0));
    ar_q.push_back(tagged_a(client_ar_data_i[1], 1));
    @(negedge clk_i) chk("ar_rr0", 128'(client_ar_ready_o), 2'b01);
    step();
    client_ar_valid_i = 2'b10;
    @(negedge clk_i) chk("ar_rr1", 128'(client_ar_ready_o), 2'b10);
    step();
    client_ar_valid_i = 2'b00;
    master_ar_ready_i = 1'b0;
    client_ar_data_i[1] = mk_a(6'd3, 32'h300, 8'd0);
    client_ar_valid_i = 2'b10;
    ar_q.push_back(tagged_a(client_ar_data_i[1], 1));
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_i);
      chk("ar_hold_data", 128'(master_ar_data_o), tagged_a(client_ar_data_i[1], 1));
      chk("ar_hold_rdy", 128'(client_ar_ready_o), 0);
      step();
      if (k == 0) begin
        client_ar_data_i[0] = mk_a(6'd4, 32'h400, 8'd0);
        client_ar_valid_i = 2'b11;
        ar_q.push_back(tagged_a(client_ar_data_i[0], 0));
      end
    end
    master_ar_ready_i = 1'b1;
    @(negedge clk_i) chk("ar_lock_win", 128'(client_ar_ready_o), 2'b10);
    step();
    client_ar_valid_i = 2'b01;
    @(negedge clk_i) chk("ar_next", 128'(client_ar_ready_o), 2'b01);
    step();
    client_ar_data_i[0] = mk_a(6'd5, 32'h500, 8'd0);
    client_ar_data_i[1] = mk_a(6'd6, 32'h600, 8'd0);
    client_ar_valid_i = 2'b11;
    ar_q.push_back(tagged_a(client_ar_data_i[1], 1));
    ar_q.push_back(tagged_a(client_ar_data_i[0], 0));
    @(negedge clk_i) chk("ar_rot1", 128'(client_ar_ready_o), 2'b10);
    step();
    client_ar_valid_i = 2'b01;
    @(negedge clk_i) chk("ar_rot0", 128'(client_ar_ready_o), 2'b01);
    step();
    client_ar_valid_i = 2'b00;
    master_ar_ready_i = 1'b0;
    client_aw_data_i[0] = mk_a(6'd1, 32'h1000, 8'd3);
    client_aw_data_i[1] = mk_a(6'd2, 32'h2000, 8'd0);
    client_aw_valid_i = 2'b11;
    master_aw_ready_i = 1'b1;
    master_w_ready_i = 1'b1;
    client_w_data_i[1] = mk_w(64'hBBBB, 1'b1);
    client_w_valid_i = 2'b10;
    aw_q.push_back(tagged_a(client_aw_data_i[0], 0));
    aw_q.push_back(tagged_a(client_aw_data_i[1], 1));
    for (int b = 0; b < 4; b++) w_q.push_back(128'(mk_w(64'hA0 + 64'(b), b == 3)));
    w_q.push_back(128'(client_w_data_i[1]));
    @(negedge clk_i);
    chk("aw_first", 128'(client_aw_ready_o), 2'b01);
    chk("w_pre_aw", 128'(client_w_ready_o), 0);
    step();
    client_aw_valid_i = 2'b10;
    for (int b = 0; b < 4; b++) begin
      client_w_data_i[0] = mk_w(64'hA0 + 64'(b), b == 3);
      client_w_valid_i = 2'b11;
      @(negedge clk_i);
      chk("aw_blocked", {client_aw_ready_o, master_aw_valid_o}, 0);
      chk("w_owner0", 128'(client_w_ready_o), 2'b01);
      step();
    end
    client_w_valid_i = 2'b10;
    @(negedge clk_i);
    chk("aw_after", 128'(client_aw_ready_o), 2'b10);
    chk("w_same_cyc", 128'(client_w_ready_o), 0);
    step();
    client_aw_valid_i = 2'b00;
    @(negedge clk_i) chk("w_owner1", 128'(client_w_ready_o), 2'b10);
    step();
    client_w_valid_i = 2'b00;
    client_r_ready_i = 2'b10;
    master_r_valid_i = 1'b1;
    master_r_data_i = mk_r(6'h00, 64'hD0);
    r_q.push_back({8'd0, mk_r(6'h00, 64'hD0)});
    for (int k = 0; k < 2; k++) begin
      @(negedge clk_i);
      chk("r_stall", 128'(master_r_ready_o), 0);
      chk("r_dest0", 128'(client_r_valid_o), 2'b01);
      step();
    end
    client_r_ready_i = 2'b11;
    @(negedge clk_i) chk("r_go", 128'(master_r_ready_o), 1);
    step();
    master_r_data_i = mk_r(6'h25, 64'hD1);
    r_q.push_back({8'd1, mk_r(6'h05, 64'hD1)});
    @(negedge clk_i) chk("r_dest1", 128'(client_r_valid_o), 2'b10);
    step();
    master_r_data_i = mk_r(6'h02, 64'hD2);
    r_q.push_back({8'd0, mk_r(6'h02, 64'hD2)});
    @(negedge clk_i) chk("r_dest0b", 128'(client_r_valid_o), 2'b01);
    step();
    master_r_valid_i = 1'b0;
    client_b_ready_i = 2'b01;
    master_b_valid_i = 1'b1;
    master_b_data_i = '{id: 6'h23, resp: 2'd2};
    b_q.push_back({8'd1, 6'h03, 2'd2});
    for (int k = 0; k < 2; k++) begin
      @(negedge clk_i);
      chk("b_stall", 128'(master_b_ready_o), 0);
      chk("b_dest", 128'(client_b_valid_o), 2'b10);
      step();
    end
    client_b_ready_i = 2'b11;
    @(negedge clk_i);
    chk("b_go", 128'(master_b_ready_o), 1);
    chk("b_dest_go", 128'(client_b_valid_o), 2'b10);
    step();
    master_b_valid_i = 1'b0;
    client_aw_data_i[0] = mk_a(6'd7, 32'h3000, 8'd1);
    client_aw_valid_i = 2'b01;
    aw_q.push_back(tagged_a(client_aw_data_i[0], 0));
    w_q.push_back(128'(mk_w(64'hC0, 1'b0)));
    @(negedge clk_i) chk("aw_pre_rst", 128'(client_aw_ready_o), 2'b01);
    step();
    client_aw_valid_i = 2'b00;
    client_w_data_i[0] = mk_w(64'hC0, 1'b0);
    client_w_valid_i = 2'b01;
    @(negedge clk_i) chk("w_pre_rst", 128'(client_w_ready_o), 2'b01);
    step();
    client_w_data_i[0] = mk_w(64'hC1, 1'b0);
    reset_n_i = 1'b0;
    @(negedge clk_i) chk("rst_mid", 128'(hs_outs), 0);
    step();
    reset_n_i = 1'b1;
    client_aw_data_i[0] = mk_a(6'd8, 32'h4000, 8'd0);
    client_aw_data_i[1] = mk_a(6'd9, 32'h5000, 8'd0);
    client_aw_valid_i = 2'b11;
    aw_q.push_back(tagged_a(client_aw_data_i[0], 0));
    aw_q.push_back(tagged_a(client_aw_data_i[1], 1));
    w_q.push_back(128'(mk_w(64'hC2, 1'b1)));
    w_q.push_back(128'(mk_w(64'hE2, 1'b1)));
    @(negedge clk_i);
    chk("rst_w_idle", 128'(client_w_ready_o), 0);
    chk("rst_ptr", 128'(client_aw_ready_o), 2'b01);
    step();
    client_aw_valid_i = 2'b10;
    client_w_data_i[0] = mk_w(64'hC2, 1'b1);
    @(negedge clk_i) chk("w_post_rst", 128'(client_w_ready_o), 2'b01);
    step();
    client_w_valid_i = 2'b00;
    @(negedge clk_i) chk("aw_post_rst1", 128'(client_aw_ready_o), 2'b10);
    step();
    client_aw_valid_i = 2'b00;
    client_w_data_i[1] = mk_w(64'hE2, 1'b1);
    client_w_valid_i = 2'b10;
    @(negedge clk_i) chk("w_post_rst1", 128'(client_w_ready_o), 2'b10);
    step();
    client_w_valid_i = 2'b00;
    step();
    chk("ar_q_left", 128'(ar_q.size()), 0);
    chk("aw_q_left", 128'(aw_q.size()), 0);
    chk("w_q_left", 128'(w_q.size()), 0);
    chk("b_q_left", 128'(b_q.size()), 0);
    chk("r_q_left", 128'(r_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
